// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the store buffer
// Purpose: data width, default depth and the stored-entry layout used by the
//          store buffer, its interface and the bench.
// Contents: XLEN, SB_DEPTH, sb_entry_t {waddr, data, be}.
package store_buffer_pkg;

  localparam int XLEN     = 32;
  localparam int SB_DEPTH = 4;

  // One pending store: word address (byte offset dropped), lane-aligned data
  // and byte enables.
  typedef struct packed {
    logic [XLEN-3:0] waddr;
    logic [XLEN-1:0] data;
    logic [3:0]      be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store, load-check and dmem signals of the store buffer
// Purpose: bundles every non-clock/reset signal of store_buffer.
// Ports:   slave  - the store buffer itself
//          master - the pipeline/dmem environment driving it
//  store side : st_valid, st_ready, st_addr, st_wdata, st_be
//  load check : ld_chk_valid, ld_chk_addr, ld_hazard
//  dmem side  : mem_req, mem_addr, mem_wdata, mem_be, mem_gnt
//  status     : empty, count
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) ();

  logic                       st_valid;
  logic                       st_ready;
  logic [XLEN-1:0]            st_addr;
  logic [XLEN-1:0]            st_wdata;
  logic [3:0]                 st_be;
  logic                       ld_chk_valid;
  logic [XLEN-1:0]            ld_chk_addr;
  logic                       ld_hazard;
  logic                       mem_req;
  logic [XLEN-1:0]            mem_addr;
  logic [XLEN-1:0]            mem_wdata;
  logic [3:0]                 mem_be;
  logic                       mem_gnt;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be,
    input  ld_chk_valid, ld_chk_addr,
    input  mem_gnt,
    output st_ready, ld_hazard,
    output mem_req, mem_addr, mem_wdata, mem_be,
    output empty, count
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_be,
    output ld_chk_valid, ld_chk_addr,
    output mem_gnt,
    input  st_ready, ld_hazard,
    input  mem_req, mem_addr, mem_wdata, mem_be,
    input  empty, count
  );

endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer between store alignment and dmem
// Purpose: queues aligned stores, retires them in program order over a
//          req/gnt handshake and flags loads that hit a pending store word.
// Ports:
//  clk   - clock, all state on the rising edge
//  rst_n - synchronous active-low reset
//  bus   - store_buffer_if.slave (store, load-check, dmem and status signals)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  sb_entry_t         r_mem [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;

  logic              w_st_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  sb_entry_t         w_head;
  sb_entry_t         w_new;
  logic [DEPTH-1:0]  w_match;
  logic              w_new_match;

  // Ready depends only on registered occupancy, so a full buffer never
  // accepts even when the head retires in the same cycle.
  assign w_st_ready = rst_n && (r_count != CNT_FULL);
  assign w_nonempty = (r_count != '0);

  // Zero-byte-enable stores are handshaken but never occupy an entry.
  assign w_push = bus.st_valid && w_st_ready && (bus.st_be != 4'b0000);
  assign w_pop  = w_nonempty && bus.mem_gnt;

  assign w_new = '{waddr: bus.st_addr[XLEN-1:2], data: bus.st_wdata, be: bus.st_be};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Push and pop never hit the same slot: a pop needs a non-empty
      // buffer and a push a non-full one, so the pointers differ.
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; r_vld and r_count qualify every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  assign w_head = w_nonempty ? r_mem[r_rd_ptr] : '0;

  // Hazard compare: every occupied entry (including one retiring now) plus
  // the store being written this cycle.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_vld[i] && (r_mem[i].waddr == bus.ld_chk_addr[XLEN-1:2]);
    end
  end

  assign w_new_match = w_push && (bus.st_addr[XLEN-1:2] == bus.ld_chk_addr[XLEN-1:2]);

  assign bus.st_ready  = w_st_ready;
  assign bus.mem_req   = w_nonempty;
  assign bus.mem_addr  = {w_head.waddr, 2'b00};
  assign bus.mem_wdata = w_head.data;
  assign bus.mem_be    = w_head.be;
  assign bus.empty     = !w_nonempty;
  assign bus.count     = r_count;
  assign bus.ld_hazard = bus.ld_chk_valid && ((|w_match) || w_new_match);

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = SB_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;

  sb_entry_t q[$];

  store_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of pending stores.
  initial begin : model
    bit        pop;
    bit        push;
    sb_entry_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        started = 1'b1;
      end else if (started) begin
        pop  = (q.size() != 0) && (bus.mem_gnt === 1'b1);
        push = (bus.st_valid === 1'b1) && (q.size() != DEPTH) && (bus.st_be != 4'b0000);
        e    = '{waddr: bus.st_addr[XLEN-1:2], data: bus.st_wdata, be: bus.st_be};
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin : compare
    logic            e_ready;
    logic            e_hz;
    logic [XLEN-1:0] e_addr;
    logic [XLEN-1:0] e_data;
    logic [3:0]      e_be;
    forever begin
      @(negedge clk);
      if (started) begin
        e_ready = rst_n && (q.size() != DEPTH);
        if (q.size() != 0) begin
          e_addr = {q[0].waddr, 2'b00};
          e_data = q[0].data;
          e_be   = q[0].be;
        end else begin
          e_addr = '0;
          e_data = '0;
          e_be   = '0;
        end
        e_hz = 1'b0;
        foreach (q[i]) if (q[i].waddr == bus.ld_chk_addr[XLEN-1:2]) e_hz = 1'b1;
        if (bus.st_valid && e_ready && bus.st_be != 4'b0000 &&
            bus.st_addr[XLEN-1:2] == bus.ld_chk_addr[XLEN-1:2]) e_hz = 1'b1;
        e_hz = e_hz && bus.ld_chk_valid;
        chk("st_ready",  bus.st_ready,  e_ready);
        chk("mem_req",   bus.mem_req,   q.size() != 0);
        chk("mem_addr",  bus.mem_addr,  e_addr);
        chk("mem_wdata", bus.mem_wdata, e_data);
        chk("mem_be",    bus.mem_be,    e_be);
        chk("empty",     bus.empty,     q.size() == 0);
        chk("count",     bus.count,     q.size());
        chk("ld_hazard", bus.ld_hazard, e_hz);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic [3:0] be);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_wdata = d;
    bus.st_be    = be;
  endtask

  initial begin : stim
    bus.st_valid     = 1'b0;
    bus.st_addr      = '0;
    bus.st_wdata     = '0;
    bus.st_be        = '0;
    bus.ld_chk_valid = 1'b0;
    bus.ld_chk_addr  = '0;
    bus.mem_gnt      = 1'b0;
    rst_n            = 1'b0;
    step();
    step();
    chk("reset count", bus.count, 0);
    chk("reset empty", bus.empty, 1);
    chk("reset ready", bus.st_ready, 0);
    rst_n = 1'b1;
    step();

    // single store retired at once
    bus.mem_gnt = 1'b1;
    store(32'h100, 32'h0000AB00, 4'b0010);
    step();
    bus.st_valid = 1'b0;
    chk("t1 mem_req", bus.mem_req, 1);
    chk("t1 mem_addr", bus.mem_addr, 32'h100);
    chk("t1 mem_be", bus.mem_be, 4'b0010);
    step();
    chk("t1 empty", bus.empty, 1);

    // fill while dmem stalls, then drain
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h300 + 4 * i, 32'hA000_0000 + i, 4'hF);
      step();
    end
    store(32'h310, 32'hA000_0004, 4'hF);
    chk("t2 count full", bus.count, 4);
    chk("t2 ready full", bus.st_ready, 0);
    step();
    step();
    chk("t2 count held", bus.count, 4);
    chk("t2 head held", bus.mem_addr, 32'h300);
    bus.mem_gnt = 1'b1;
    step();
    chk("t2 ready after gnt", bus.st_ready, 1);
    chk("t2 second head", bus.mem_addr, 32'h304);
    step();
    bus.st_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t2 drained", bus.empty, 1);

    // steady enqueue+dequeue across pointer wrap
    bus.mem_gnt = 1'b0;
    store(32'h400, 32'hB000_0000, 4'hF);
    step();
    store(32'h404, 32'hB000_0001, 4'hF);
    step();
    bus.mem_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      store(32'h408 + 4 * k, $urandom, 4'(1 + $urandom_range(0, 14)));
      step();
    end
    chk("t3 count steady", bus.count, 2);
    chk("t3 head order", bus.mem_addr, 32'h428);
    bus.st_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // load hazard
    bus.mem_gnt = 1'b0;
    store(32'h204, 32'h1234_0000, 4'b1100);
    step();
    bus.st_valid     = 1'b0;
    bus.ld_chk_valid = 1'b1;
    bus.ld_chk_addr  = 32'h206;
    #1;
    chk("t4 hazard hit", bus.ld_hazard, 1);
    bus.ld_chk_addr = 32'h208;
    #1;
    chk("t4 hazard miss", bus.ld_hazard, 0);
    bus.mem_gnt = 1'b1;
    step();
    step();
    bus.ld_chk_addr = 32'h206;
    #1;
    chk("t4 hazard drained", bus.ld_hazard, 0);
    bus.ld_chk_valid = 1'b0;

    // zero byte enables
    store(32'h500, 32'hDEAD, 4'b0000);
    #1;
    chk("t5 ready", bus.st_ready, 1);
    step();
    chk("t5 count", bus.count, 0);
    chk("t5 no req", bus.mem_req, 0);
    bus.st_valid = 1'b0;
    step();

    // reset discards pending entries
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h600 + 4 * i, 32'hC000_0000 + i, 4'hF);
      step();
    end
    bus.st_valid = 1'b0;
    chk("t6 count3", bus.count, 3);
    chk("t6 req", bus.mem_req, 1);
    rst_n = 1'b0;
    step();
    chk("t6 count0", bus.count, 0);
    chk("t6 req0", bus.mem_req, 0);
    chk("t6 empty", bus.empty, 1);
    chk("t6 ready in reset", bus.st_ready, 0);
    rst_n       = 1'b1;
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6 no stale req", bus.mem_req, 0);
    end

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.st_valid     = ($urandom_range(0, 99) < 60);
      bus.st_addr      = 32'h200 + $urandom_range(0, 31);
      bus.st_wdata     = $urandom;
      bus.st_be        = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
      bus.mem_gnt      = ($urandom_range(0, 99) < 45);
      bus.ld_chk_valid = ($urandom_range(0, 1) == 1);
      bus.ld_chk_addr  = 32'h200 + $urandom_range(0, 31);
      step();
    end
    bus.st_valid = 1'b0;
    bus.mem_gnt  = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    chk("final empty", bus.empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
